// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity frame checker.
package parity_pkg;

  // Frame checker control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Parity mode encodings for the odd input and the latched frame mode.
  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Word stream in, held integrity result out.
//
// Handshake rules: a beat transfers on a rising edge where s_valid & s_ready
// are both high. The result transfers on a rising edge where
// res_valid & res_ready are both high. The producer holds its payload stable
// while valid is high and ready is low. s_valid may drop between beats.
interface parity_frame_checker_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
);
  logic             odd;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [WIDTH-1:0] res_syndrome;
  logic             res_parity;
  logic [LEN_W-1:0] res_len;
  logic             res_ovf;

  // Word source plus result consumer side.
  modport master (
    output odd, s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_ok, res_syndrome, res_parity, res_len, res_ovf
  );

  // Checker side.
  modport slave (
    input  odd, s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_ok, res_syndrome, res_parity, res_len, res_ovf
  );
endinterface

// File: rtl/xor_fold.sv
// Balanced XOR reduction tree: one parity bit from a WIDTH-bit word.
module xor_fold #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);
  // Pad to a power of two so each tree level halves cleanly.
  localparam int P2 = 1 << $clog2(WIDTH);

  // Pairwise fold, level by level; index i only reads 2i and 2i+1, so the
  // in-place update never consumes a value already written on this level.
  function automatic logic fold(input logic [WIDTH-1:0] v);
    logic [P2-1:0] t;
    t = P2'(v);
    for (int w = P2 / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        t[i] = t[2*i] ^ t[2*i+1];
      end
    end
    return t[0];
  endfunction

  // Pure combinational reduction; the caller registers the result.
  always_comb begin
    parity_o = fold(data_i);
  end
endmodule

// File: rtl/parity_frame_checker.sv
// Streaming column-parity checker: XORs every data word of a frame, compares
// against the trailing check word in even or odd mode, and holds the result
// until the consumer takes it. Also keeps a saturating failed-frame count.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int ERR_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_frame_checker_if.slave bus,
  output logic [ERR_W-1:0]      err_cnt,
  output state_t                dbg_state
);

  state_t             state_q;
  logic               mode_q;
  logic [WIDTH-1:0]   acc_q;
  logic [LEN_W-1:0]   len_q;
  logic               s_ready_q;
  logic               res_valid_q;
  logic               res_ok_q;
  logic [WIDTH-1:0]   res_syn_q;
  logic               res_par_q;
  logic [LEN_W-1:0]   res_len_q;
  logic               res_ovf_q;
  logic [ERR_W-1:0]   err_q;

  logic               beat;
  logic               check_beat;
  logic               mode_d;
  logic [WIDTH-1:0]   acc_base;
  logic [WIDTH-1:0]   syn_d;
  logic               par_d;
  logic               ovf_d;
  logic               ok_d;
  logic [LEN_W-1:0]   len_d;
  logic               err_inc;

  // Result candidate for the current beat, assuming it is the check word.
  // In IDLE the beat is also the first of the frame, so mode comes straight
  // from the input and the accumulator is treated as empty.
  always_comb begin
    beat       = bus.s_valid & s_ready_q;
    check_beat = beat & bus.s_last;
    mode_d     = (state_q == IDLE) ? bus.odd : mode_q;
    acc_base   = (state_q == IDLE) ? '0 : acc_q;
    len_d      = (state_q == IDLE) ? '0 : len_q;
    ovf_d      = (state_q == DRAIN);
    syn_d      = acc_base ^ bus.s_data ^ {WIDTH{mode_d == MODE_ODD}};
    ok_d       = (syn_d == '0) && !ovf_d;
    err_inc    = check_beat && !ok_d && (err_q != '1);
  end

  xor_fold #(.WIDTH(WIDTH)) u_fold (
    .data_i   (syn_d),
    .parity_o (par_d)
  );

  // Frame FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_EVEN;
      acc_q       <= '0;
      len_q       <= '0;
      s_ready_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
      res_syn_q   <= '0;
      res_par_q   <= 1'b0;
      res_len_q   <= '0;
      res_ovf_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      if (check_beat) begin
        // Any state that accepts beats ends the frame here.
        res_valid_q <= 1'b1;
        res_ok_q    <= ok_d;
        res_syn_q   <= syn_d;
        res_par_q   <= par_d;
        res_len_q   <= len_d;
        res_ovf_q   <= ovf_d;
        s_ready_q   <= 1'b0;
        state_q     <= RESULT;
        if (err_inc) begin
          err_q <= err_q + ERR_W'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (beat) begin
            mode_q <= bus.odd;
            if (!bus.s_last) begin
              acc_q   <= bus.s_data;
              len_q   <= LEN_W'(1);
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat && !bus.s_last) begin
            if (len_q == LEN_W'(MAX_LEN)) begin
              // Too many data words: freeze acc/len and wait for the check.
              state_q <= DRAIN;
            end else begin
              acc_q <= acc_q ^ bus.s_data;
              len_q <= len_q + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          // Data beats are swallowed; the check beat is handled above.
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            s_ready_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_ok       = res_ok_q;
  assign bus.res_syndrome = res_syn_q;
  assign bus.res_parity   = res_par_q;
  assign bus.res_len      = res_len_q;
  assign bus.res_ovf      = res_ovf_q;
  assign err_cnt          = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: directed frames with literal expectations,
// then randomized frames, all tracked by a frame-level reference model.
module tb_parity_frame_checker;
  import parity_pkg::*;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int LW = $clog2(ML + 1);
  localparam int EW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_frame_checker_if #(.WIDTH(W), .LEN_W(LW)) bus ();
  logic [EW-1:0] err_cnt;
  state_t        dbg_state;

  parity_frame_checker #(.WIDTH(W), .MAX_LEN(ML), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit rnd_gap = 1'b0;
  logic [W-1:0] frm [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];   // expected syndrome of the pending result
  logic [W-1:0]  m_data[$];  // data words of the frame in progress
  bit            m_hold, m_in_frame, m_mode;
  bit            e_ok, e_par, e_ovf;
  int            e_len;
  int            m_err;

  function automatic void model_reset();
    m_hold = 0; m_in_frame = 0; m_mode = 0; m_err = 0;
    m_data.delete(); exp_q.delete();
  endfunction

  function automatic void model_beat(input logic [W-1:0] d, input bit last, input bit o);
    logic [W-1:0] acc, syn;
    int n;
    if (!m_in_frame) begin
      m_in_frame = 1;
      m_mode = o;
    end
    if (!last) begin
      m_data.push_back(d);
      return;
    end
    n = m_data.size();
    acc = '0;
    for (int i = 0; i < n && i < ML; i++) acc ^= m_data[i];
    syn   = acc ^ d ^ (m_mode ? {W{1'b1}} : {W{1'b0}});
    e_ovf = (n > ML);
    e_len = e_ovf ? ML : n;
    e_ok  = (syn == 0) && !e_ovf;
    e_par = ($countones(syn) % 2) == 1;
    if (!e_ok && m_err < (1 << EW) - 1) m_err++;
    exp_q.push_back(syn);
    m_hold = 1; m_in_frame = 0;
    m_data.delete();
  endfunction

  // Per-cycle compare, then advance the model with what the next edge sees.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_ready", bus.s_ready, !m_hold);
      chk("res_valid", bus.res_valid, m_hold);
      chk("err_cnt", err_cnt, m_err);
      if (m_hold) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
        else chk("res_syndrome", bus.res_syndrome, exp_q[0]);
        chk("res_ok", bus.res_ok, e_ok);
        chk("res_parity", bus.res_parity, e_par);
        chk("res_len", bus.res_len, e_len);
        chk("res_ovf", bus.res_ovf, e_ovf);
      end
      if (rst) model_reset();
      else if (m_hold) begin
        if (bus.res_ready) begin
          m_hold = 0;
          void'(exp_q.pop_front());
        end
      end else if (bus.s_valid) begin
        model_beat(bus.s_data, bus.s_last, bus.odd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+#1.
  task automatic send_beat(input logic [W-1:0] d, input bit l, input bit o);
    int n;
    if (rnd_gap) repeat ($urandom_range(0, 1)) begin
      bus.odd = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l; bus.odd = o;
    n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) chk("beat_timeout", n, 0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_data = W'($urandom); bus.odd = 1'($urandom);
  endtask

  // Sends frm[0..n-1] plus the check word, then waits for the result (at a negedge).
  task automatic run_frame(input int n, input bit odd0, input bit tog, input logic [W-1:0] cw);
    int k;
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) begin
      bit o;
      o = (i == 0) ? odd0 : (tog ? ~odd0 : odd0);
      send_beat((i == n) ? cw : frm[i], i == n, o);
    end
    k = 0;
    @(negedge clk);
    while (!bus.res_valid && k < 20) begin k++; @(negedge clk); end
    chk("res_latency", k, 0);
  endtask

  // Holds the result for 'hold' cycles (optionally offering junk beats), then takes it.
  task automatic consume(input int hold, input bit offer);
    repeat (hold) begin
      @(posedge clk); #1;
      bus.s_valid = offer; bus.s_data = W'($urandom); bus.s_last = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic lit(input string tag, input logic [W-1:0] syn, input bit ok, input bit par,
                     input int len, input bit ovf, input int err);
    chk({tag, "_syn"}, bus.res_syndrome, syn);
    chk({tag, "_model_syn"}, (exp_q.size() > 0) ? exp_q[0] : ~syn, syn);
    chk({tag, "_ok"}, bus.res_ok, ok);
    chk({tag, "_par"}, bus.res_parity, par);
    chk({tag, "_len"}, bus.res_len, len);
    chk({tag, "_ovf"}, bus.res_ovf, ovf);
    chk({tag, "_err"}, err_cnt, err);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.odd = 0; bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0; bus.res_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_ok", bus.res_ok, 0);
    chk("rst_res_ovf", bus.res_ovf, 0);
    chk("rst_res_parity", bus.res_parity, 0);
    chk("rst_res_syndrome", bus.res_syndrome, 0);
    chk("rst_res_len", bus.res_len, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state", dbg_state, IDLE);

    // Even pass.
    frm[0] = 8'h0F; frm[1] = 8'hF0;
    run_frame(2, 0, 0, 8'hFF); lit("even", 8'h00, 1, 0, 2, 0, 0); consume(0, 0);
    // Odd pass.
    run_frame(2, 1, 0, 8'h00); lit("odd", 8'h00, 1, 0, 2, 0, 0); consume(1, 0);
    // Empty frame.
    run_frame(0, 0, 0, 8'h00); lit("empty", 8'h00, 1, 0, 0, 0, 0); consume(0, 0);
    // Corruption.
    frm[0] = 8'h01; frm[1] = 8'h02;
    run_frame(2, 0, 0, 8'h02); lit("corrupt", 8'h01, 0, 1, 2, 0, 1); consume(0, 0);
    // Overflow: words 5 and 6 must not reach the syndrome.
    frm[0] = 8'h01; frm[1] = 8'h02; frm[2] = 8'h04; frm[3] = 8'h08;
    frm[4] = 8'h10; frm[5] = 8'h20;
    run_frame(6, 0, 0, 8'h0F); lit("ovf", 8'h00, 0, 0, 4, 1, 2); consume(0, 0);
    // Mode latched on the first beat, with backpressure and offered beats.
    frm[0] = 8'h0F; frm[1] = 8'hF0;
    run_frame(2, 1, 1, 8'h00); lit("mode", 8'h00, 1, 0, 2, 0, 2); consume(3, 1);
    // Saturating error count.
    frm[0] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 0, 0, 8'h00); lit("sat", 8'h01, 0, 1, 1, 0, 3); consume(0, 0);
    end
    // Reset mid-frame.
    @(posedge clk); #1;
    send_beat(8'h33, 0, 1);
    send_beat(8'h44, 0, 1);
    pulse_reset();
    @(negedge clk);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_syn", bus.res_syndrome, 0);
    chk("mid_rst_state", dbg_state, IDLE);
    frm[0] = 8'h0F; frm[1] = 8'hF0;
    run_frame(2, 0, 0, 8'hFF); lit("post_rst", 8'h00, 1, 0, 2, 0, 0); consume(0, 0);

    // Randomized frames.
    rnd_gap = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      bit o0, tg;
      logic [W-1:0] cw, acc;
      n = $urandom_range(0, 6);
      o0 = 1'($urandom); tg = 1'($urandom);
      acc = '0;
      for (int i = 0; i < n; i++) begin
        frm[i] = W'($urandom);
        if (i < ML) acc ^= frm[i];
      end
      cw = ($urandom_range(0, 1) == 1) ? (acc ^ (o0 ? {W{1'b1}} : {W{1'b0}})) : W'($urandom);
      run_frame(n, o0, tg, cw);
      consume($urandom_range(0, 3), 1'($urandom));
      if (f % 10 == 9) pulse_reset();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Streaming, parametrised successor to the fixed 8-input XOR parity tree. It accepts a framed stream of WIDTH-bit words over a valid/ready handshake and accumulates column (bitwise) parity across every data word of the frame. It compares the result against the trailing check word in even or odd mode, then presents a held result: syndrome, pass flag, frame length and overflow. It sits between an input word source and any consumer of integrity status, and also keeps a saturating error count.

## Interface
- WIDTH, 8, data/check word width in bits (≥2)
- MAX_LEN, 16, max data words per frame, check word excluded (≥1)
- LEN_W, $clog2(MAX_LEN+1), width of res_len
- ERR_W, 8, width of saturating error counter

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- odd  in  1  parity mode, sampled on a frame's first accepted beat: 0 even, 1 odd
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  WIDTH  data word, or check word when s_last=1
- s_last  in  1  marks the check word, which ends the frame
- res_valid  out  1  result held valid
- res_ready  in  1  consumer takes result when res_valid & res_ready
- res_ok  out  1  syndrome==0 and no overflow
- res_syndrome  out  WIDTH  acc ^ check ^ (odd ? all-ones : 0)
- res_parity  out  1  XOR-reduction of res_syndrome
- res_len  out  LEN_W  data words counted, saturating at MAX_LEN
- res_ovf  out  1  frame exceeded MAX_LEN data words
- err_cnt  out  ERR_W  count of frames with res_ok=0, saturating at all-ones

## Operation
- FSM states: IDLE, ACCUM, DRAIN, RESULT.
- IDLE: s_ready=1. On an accepted beat, latch odd into mode_q.
  - Beat with s_last=0: acc=s_data, len=1, go to ACCUM.
  - Beat with s_last=1: empty frame. acc=0, len=0, the beat is the check word, go to RESULT.
- ACCUM: s_ready=1.
  - Data beat with len<MAX_LEN: acc^=s_data, len++.
  - Data beat with len==MAX_LEN: set ovf, go to DRAIN. acc and len are frozen.
  - Check beat: compute the result and go to RESULT.
- DRAIN: s_ready=1. Data beats are discarded. The check beat ends the frame and goes to RESULT, with the syndrome computed from the frozen acc.
- RESULT: s_ready=0, res_valid=1, all res_* outputs stable. On res_ready, go to IDLE.
- err_cnt increments exactly once per frame with res_ok=0, on the cycle the check beat is accepted. It holds at 2^ERR_W−1.
- Outputs after reset:
  - s_ready=1
  - res_valid=0, res_ok=0, res_ovf=0, res_parity=0
  - res_syndrome=0, res_len=0, err_cnt=0
- res_* values outside RESULT hold the last result. They are don't-care for checking; they are only zeroed by reset.

## Timing
- Check beat accepted at cycle N → res_valid=1 at N+1 (registered, 1-cycle latency).
- Result is consumed at cycle M (res_valid & res_ready) → s_ready=1 at M+1. There is no same-cycle result-consume-and-accept bypass, so minimum frame spacing is 1 idle cycle.
- res_valid stays asserted while res_ready is low, for any number of cycles. No input beats are accepted during that time.
- The odd input is ignored on every beat except the first beat of a frame.
- rst asserted in any state, including mid-frame or RESULT: on the next edge, return to IDLE and clear all state and err_cnt. The partial frame is lost and no result is produced.
- s_valid is allowed to toggle between beats. Only handshaked beats affect state.

## Structure
- parity_pkg:
  - state enum (IDLE/ACCUM/DRAIN/RESULT)
  - mode constants MODE_EVEN=1'b0, MODE_ODD=1'b1
- Sub-module xor_fold #(WIDTH): balanced XOR reduction tree giving res_parity from res_syndrome. It is combinational, and its output is registered in the top block.

## Test plan
All scenarios use WIDTH=8, MAX_LEN=4, ERR_W=2.
- Even pass: odd=0, data 0x0F, 0xF0, check 0xFF → res_syndrome=0x00, res_ok=1, res_len=2, res_valid 1 cycle after the check beat, err_cnt=0.
- Odd pass and empty frame:
  - odd=1, data 0x0F, 0xF0, check 0x00 → res_syndrome=0x00, res_ok=1.
  - odd=0, single beat 0x00 with s_last=1 → res_len=0, res_ok=1.
- Corruption: odd=0, data 0x01, 0x02, check 0x02 → res_syndrome=0x01, res_parity=1, res_ok=0, err_cnt=1.
- Overflow: 6 data words, then check → res_ovf=1, res_len=4, res_ok=0. The 5th and 6th words do not alter the syndrome.
- Backpressure and mode latch:
  - Hold res_ready=0 for 3 cycles → res_* stable, s_ready=0, offered beats not accepted. On release, s_ready=1 the next cycle.
  - Toggle odd mid-frame → the result uses the first-beat mode.
- Saturation and reset:
  - 4 failing frames → err_cnt=3 and stays there.
  - Assert rst after 2 data beats → next cycle IDLE, err_cnt=0, res_valid=0. The following clean frame passes.
